// File: rtl/mul8x8_seq_sched.sv
// Sequential 8x8 unsigned multiplier that time-shares one 4x4 core over the LL, HL, LH, HH nibble quadrants.
// Optional macro APPROX_LL_EN: the LL step uses the OR-approximate n1_4x4 core instead of exact_4x4.

module exact_4x4 (
  input  logic [3:0] x,
  input  logic [3:0] w,
  output logic [7:0] p
);
  assign p = {4'b0, x} * {4'b0, w};
endmodule

// Columns 0..3 are ORed without carries; columns 4..6 are summed exactly.
module n1_4x4 (
  input  logic [3:0] x,
  input  logic [3:0] w,
  output logic [7:0] p
);
  logic [3:0] lo;
  logic [1:0] c4, c5;
  logic       c6;
  logic [7:0] hi;

  assign lo[0] = x[0] & w[0];
  assign lo[1] = (x[0] & w[1]) | (x[1] & w[0]);
  assign lo[2] = (x[0] & w[2]) | (x[1] & w[1]) | (x[2] & w[0]);
  assign lo[3] = (x[0] & w[3]) | (x[1] & w[2]) | (x[2] & w[1]) | (x[3] & w[0]);
  assign c4    = 2'(x[1] & w[3]) + 2'(x[2] & w[2]) + 2'(x[3] & w[1]);
  assign c5    = 2'(x[2] & w[3]) + 2'(x[3] & w[2]);
  assign c6    = x[3] & w[3];
  assign hi    = {2'b0, c4, 4'b0} + {1'b0, c5, 5'b0} + {1'b0, c6, 6'b0};
  assign p     = hi | {4'b0, lo};
endmodule

module mul8x8_seq_sched #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, S_LL = 3'd1, S_HL = 3'd2, S_LH = 3'd3, S_HH = 3'd4, DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc_q, acc_d, y_q, term;
  logic        accept, load_y;
  logic [3:0]  core_x, core_w, shift;
  logic [7:0]  core_p, exact_p;

  // Bit k set when quadrant k (LL, HL, LH, HH) has to run for this operand pair.
  function automatic logic [3:0] run_mask(input logic [7:0] av, input logic [7:0] bv);
    if (!SKIP_ZERO) return 4'b1111;
    return {(|av[7:4]) & (|bv[7:4]), (|av[3:0]) & (|bv[7:4]),
            (|av[7:4]) & (|bv[3:0]), (|av[3:0]) & (|bv[3:0])};
  endfunction

  // First quadrant with index >= from that has to run; DONE when none is left.
  function automatic state_t next_step(input logic [3:0] run, input logic [2:0] from);
    if      (from == 3'd0 && run[0]) return S_LL;
    else if (from <= 3'd1 && run[1]) return S_HL;
    else if (from <= 3'd2 && run[2]) return S_LH;
    else if (from <= 3'd3 && run[3]) return S_HH;
    return DONE;
  endfunction

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    core_x = a_q[3:0];
    core_w = b_q[3:0];
    shift  = 4'd0;
    case (state_q)
      S_HL: begin core_x = a_q[7:4]; shift = 4'd4; end
      S_LH: begin core_w = b_q[7:4]; shift = 4'd4; end
      S_HH: begin core_x = a_q[7:4]; core_w = b_q[7:4]; shift = 4'd8; end
      default: ;
    endcase
  end

  exact_4x4 u_core (.x(core_x), .w(core_w), .p(exact_p));

`ifdef APPROX_LL_EN
  logic [7:0] approx_p;
  n1_4x4 u_core_ll (.x(a_q[3:0]), .w(b_q[3:0]), .p(approx_p));
  assign core_p = (state_q == S_LL) ? approx_p : exact_p;
`else
  assign core_p = exact_p;
`endif

  assign term = {8'b0, core_p} << shift;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      S_LL, S_HL, S_LH, S_HH: begin
        acc_d   = acc_q + term;
        state_d = next_step(run_mask(a_q, b_q), state_q);
      end
      DONE: begin
        in_ready = out_ready;
        accept   = in_valid & out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      acc_d   = '0;
      state_d = next_step(run_mask(a, b), 3'd0);
    end
  end

  // y is refreshed only when a fresh result enters DONE (from a step, or an all-skipped accept).
  assign load_y = (state_d == DONE) && ((state_q != DONE) || accept);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if (load_y) y_q <= acc_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;
endmodule

// File: tb/tb_mul8x8_seq_sched.sv
// Self-checking bench for mul8x8_seq_sched: one full-schedule and one zero-skipping instance
// against a cycle-level behavioural model, plus directed literal cases.
module tb_mul8x8_seq_sched;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0][7:0]  a, b;
  logic [1:0][15:0] y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_phase [2];
  int m_left  [2];
  int m_y     [2];
  int sb0 [$];
  int sb1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul8x8_seq_sched #(.SKIP_ZERO(1'b0)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .y(y[0]), .busy(busy[0])
  );

  mul8x8_seq_sched #(.SKIP_ZERO(1'b1)) dut_skip (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .y(y[1]), .busy(busy[1])
  );

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic int nib(input int v, input int k);
    return (v >> (4 * k)) & 15;
  endfunction

  // Approximate 4x4: carry-free OR of columns 0..3 replaces their exact sum.
  function automatic int approx4(input int x, input int w);
    int lowsum = 0;
    int ormask = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i + j < 4 && ((x >> i) & 1) == 1 && ((w >> j) & 1) == 1) begin
          lowsum += 1 << (i + j);
          ormask |= 1 << (i + j);
        end
    return x * w - lowsum + ormask;
  endfunction

  function automatic int model_prod(input int av, input int bv);
    int p = av * bv;
`ifdef APPROX_LL_EN
    p = p - nib(av, 0) * nib(bv, 0) + approx4(nib(av, 0), nib(bv, 0));
`endif
    return p & 'hFFFF;
  endfunction

  function automatic int model_steps(input int skip, input int av, input int bv);
    int n = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (skip == 0 || (nib(av, i) != 0 && nib(bv, j) != 0)) n++;
    return n;
  endfunction

  function automatic logic [7:0] rand_op();
    logic [3:0] lo = 4'($urandom);
    logic [3:0] hi = 4'($urandom);
    if ($urandom_range(0, 3) == 0) lo = 4'h0;
    if ($urandom_range(0, 3) == 0) hi = 4'h0;
    return {hi, lo};
  endfunction

  task automatic model_start(input int d);
    int res = model_prod(int'(a[d]), int'(b[d]));
    m_left[d] = model_steps(d, int'(a[d]), int'(b[d]));
    if (d == 0) sb0.push_back(res); else sb1.push_back(res);
    if (m_left[d] == 0) begin
      m_phase[d] = PH_DONE;
      m_y[d]     = res;
    end else begin
      m_phase[d] = PH_RUN;
    end
  endtask

  // Compare process: outputs against the model every cycle, then advance the model.
  always @(negedge clk) begin
    bit exp_ir, fire_in, fire_out;
    int expv;
    int fin;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        check("rst_in_ready", d, in_ready[d], 1);
        check("rst_out_valid", d, out_valid[d], 0);
        check("rst_busy", d, busy[d], 0);
        check("rst_y", d, y[d], 0);
        m_phase[d] = PH_IDLE;
        m_left[d]  = 0;
        m_y[d]     = 0;
        if (d == 0) sb0.delete(); else sb1.delete();
      end else begin
        exp_ir   = (m_phase[d] == PH_IDLE) || (m_phase[d] == PH_DONE && out_ready[d]);
        fire_in  = exp_ir && in_valid[d];
        fire_out = (m_phase[d] == PH_DONE) && out_ready[d];
        check("in_ready", d, in_ready[d], exp_ir);
        check("out_valid", d, out_valid[d], m_phase[d] == PH_DONE);
        check("busy", d, busy[d], m_phase[d] != PH_IDLE);
        check("y", d, y[d], m_y[d]);
        if (fire_out) begin
          expv = -1;
          if (d == 0 && sb0.size() > 0) expv = sb0.pop_front();
          if (d == 1 && sb1.size() > 0) expv = sb1.pop_front();
          check("stream", d, y[d], expv);
        end
        case (m_phase[d])
          PH_RUN: begin
            m_left[d]--;
            if (m_left[d] == 0) begin
              m_phase[d] = PH_DONE;
              fin = (d == 0) ? sb0[sb0.size() - 1] : sb1[sb1.size() - 1];
              m_y[d] = fin;
            end
          end
          PH_IDLE: if (fire_in) model_start(d);
          default: if (fire_out) begin
            if (fire_in) model_start(d); else m_phase[d] = PH_IDLE;
          end
        endcase
      end
    end
  end

  task automatic issue(input int d, input logic [7:0] av, input logic [7:0] bv, output int t_acc);
    a[d] = av;
    b[d] = bv;
    in_valid[d] = 1'b1;
    t_acc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a[d] = 8'($urandom);
        b[d] = 8'($urandom);
        return;
      end
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    check("issue_timeout", d, 0, 1);
  endtask

  task automatic wait_done(input int d, input int t_acc, input int lat, input int exp_y, input string name);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        check({name, "_lat"}, d, cyc - t_acc, lat);
        check({name, "_y"}, d, y[d], exp_y);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check({name, "_timeout"}, d, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c0, held;
    bit fired [2];
    in_valid  = '0;
    out_ready = '1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_in_ready", d, in_ready[d], 1);
      check("reset_out_valid", d, out_valid[d], 0);
      check("reset_y", d, y[d], 0);
      check("reset_busy", d, busy[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Spec literals pin the model and the latency.
    issue(0, 8'h12, 8'h34, t); wait_done(0, t, 5, 'h03A8, "full_12x34");
    issue(1, 8'h12, 8'h34, t); wait_done(1, t, 5, 'h03A8, "skip_12x34");
`ifdef APPROX_LL_EN
    issue(0, 8'h0F, 8'h0F, t); wait_done(0, t, 5, 'h00BF, "full_0Fx0F");
    issue(1, 8'h0F, 8'h0F, t); wait_done(1, t, 2, 'h00BF, "skip_0Fx0F");
    issue(0, 8'hFF, 8'hFF, t); wait_done(0, t, 5, 'hFDDF, "full_FFxFF");
`else
    issue(0, 8'h0F, 8'h0F, t); wait_done(0, t, 5, 'h00E1, "full_0Fx0F");
    issue(1, 8'h0F, 8'h0F, t); wait_done(1, t, 2, 'h00E1, "skip_0Fx0F");
    issue(0, 8'hFF, 8'hFF, t); wait_done(0, t, 5, 'hFE01, "full_FFxFF");
`endif
    issue(1, 8'h30, 8'h05, t); wait_done(1, t, 2, 'h00F0, "skip_30x05");
    issue(0, 8'h30, 8'h05, t); wait_done(0, t, 5, 'h00F0, "full_30x05");
    issue(1, 8'h00, 8'h5A, t); wait_done(1, t, 1, 'h0000, "skip_00x5A");

    // Back-pressure: result held while out_ready is low, then a same-cycle restart.
    out_ready[0] = 1'b0;
    held = model_prod('hC3, 'h5E);
    issue(0, 8'hC3, 8'h5E, t); wait_done(0, t, 5, held, "hold_C3x5E");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("hold_out_valid", 0, out_valid[0], 1);
      check("hold_in_ready", 0, in_ready[0], 0);
      check("hold_y", 0, y[0], held);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    c0 = cyc;
    issue(0, 8'h21, 8'h87, t);
    check("b2b_same_cycle", 0, t, c0);
    wait_done(0, t, 5, model_prod('h21, 'h87), "b2b_21x87");

    // Asynchronous reset in the middle of S_LH.
    issue(0, 8'hA7, 8'h9B, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 0, busy[0], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 0, out_valid[0], 0);
    check("async_rst_busy", 0, busy[0], 0);
    check("async_rst_y", 0, y[0], 0);
    check("async_rst_in_ready", 0, in_ready[0], 1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 8'h10, 8'h10, t); wait_done(0, t, 5, 'h0100, "post_rst_10x10");

    // Randomized traffic on both instances with random back-pressure.
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) fired[d] = in_valid[d] && in_ready[d];
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (!in_valid[d] || fired[d]) begin
          in_valid[d] = ($urandom_range(0, 3) != 0);
          a[d] = rand_op();
          b[d] = rand_op();
        end
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
    end

    in_valid  = '0;
    out_ready = '1;
    repeat (12) @(posedge clk);
    #1;
    check("drain_sb_full", 0, sb0.size(), 0);
    check("drain_sb_skip", 1, sb1.size(), 0);
    check("drain_busy_full", 0, busy[0], 0);
    check("drain_busy_skip", 1, busy[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
